// File: rtl/cm_window_counter.sv
// ---------------------------------------------------------------------------
// cm_window_counter
//
// Two-dimensional active-window pixel counter for the CM capture path.
// h_pos counts clocks while hsync is high, v_pos counts completed lines
// (hsync falling edges) while vsync is high. A pixel is valid when both
// positions sit strictly between their back and front porches. The porch
// inputs are captured into shadow registers on the vsync rising edge, so
// reprogramming them mid-frame only affects the following frame.
//
// Build option:
//   CM_WINDOW_COUNTER_CFG_ERR_EN  when defined, cfg_err flags an illegal
//                                 (empty) window at shadow load and any
//                                 position-counter saturation. When not
//                                 defined, cfg_err is tied to 0.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   h_back     horizontal back porch, exclusive lower bound
//   h_front    horizontal front porch, exclusive upper bound
//   v_back     vertical back porch (lines), exclusive lower bound
//   v_front    vertical front porch (lines), exclusive upper bound
//   hsync      line-active level
//   vsync      frame-active level
//   pix_valid  registered, current pixel is inside the active window
//   pix_x      active pixel column, 0-based
//   pix_y      active line index, 0-based
//   line_end   one-cycle pulse on the pix_valid falling edge
//   frame_end  one-cycle pulse on the vsync falling edge
//   cfg_err    configuration / saturation error flag
// ---------------------------------------------------------------------------
module cm_window_counter #(
    parameter int H_WIDTH = 11,
    parameter int V_WIDTH = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [H_WIDTH-1:0] h_back,
    input  logic [H_WIDTH-1:0] h_front,
    input  logic [V_WIDTH-1:0] v_back,
    input  logic [V_WIDTH-1:0] v_front,
    input  logic               hsync,
    input  logic               vsync,
    output logic               pix_valid,
    output logic [H_WIDTH-1:0] pix_x,
    output logic [V_WIDTH-1:0] pix_y,
    output logic               line_end,
    output logic               frame_end,
    output logic               cfg_err
);

    localparam logic [H_WIDTH-1:0] H_MAX = {H_WIDTH{1'b1}};
    localparam logic [V_WIDTH-1:0] V_MAX = {V_WIDTH{1'b1}};
    localparam logic [H_WIDTH-1:0] H_ONE = H_WIDTH'(1);
    localparam logic [V_WIDTH-1:0] V_ONE = V_WIDTH'(1);

    logic [H_WIDTH-1:0] h_pos;
    logic [V_WIDTH-1:0] v_pos;
    logic [H_WIDTH-1:0] sh_back;
    logic [H_WIDTH-1:0] sh_front;
    logic [V_WIDTH-1:0] sv_back;
    logic [V_WIDTH-1:0] sv_front;
    logic               hsync_d;
    logic               vsync_d;

    logic               shadow_load;
    logic               h_fall;
    logic               h_act;
    logic               v_act;
    logic               win_act;

    assign shadow_load = vsync & ~vsync_d;
    assign h_fall      = hsync_d & ~hsync;

    // Window compare works on the registered positions together with the
    // live sync levels, so a sync dropping closes the window on that edge.
    assign h_act   = (h_pos > sh_back) && (h_pos < sh_front) && hsync;
    assign v_act   = (v_pos > sv_back) && (v_pos < sv_front) && vsync;
    assign win_act = h_act && v_act;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_d <= 1'b0;
            vsync_d <= 1'b0;
        end else begin
            hsync_d <= hsync;
            vsync_d <= vsync;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_back  <= '0;
            sh_front <= '0;
            sv_back  <= '0;
            sv_front <= '0;
        end else if (shadow_load) begin
            sh_back  <= h_back;
            sh_front <= h_front;
            sv_back  <= v_back;
            sv_front <= v_front;
        end
    end

    // Positions saturate rather than wrap so an oversized porch can never
    // re-open the window after the counter runs out of range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_pos <= '0;
        end else if (!hsync) begin
            h_pos <= '0;
        end else if (h_pos != H_MAX) begin
            h_pos <= h_pos + H_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_pos <= '0;
        end else if (!vsync) begin
            v_pos <= '0;
        end else if (h_fall && (v_pos != V_MAX)) begin
            v_pos <= v_pos + V_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_valid <= 1'b0;
            pix_x     <= '0;
            line_end  <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            pix_valid <= win_act;
            line_end  <= pix_valid & ~win_act;
            frame_end <= vsync_d & ~vsync;
            // Restart the column at the first valid cycle of each line.
            if (!win_act || !pix_valid) begin
                pix_x <= '0;
            end else begin
                pix_x <= pix_x + H_ONE;
            end
        end
    end

    // pix_y advances the cycle after line_end, so the first active line
    // reports y=0; vsync low clears it even if a line_end is pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_y <= '0;
        end else if (!vsync) begin
            pix_y <= '0;
        end else if (line_end) begin
            pix_y <= pix_y + V_ONE;
        end
    end

`ifdef CM_WINDOW_COUNTER_CFG_ERR_EN
    localparam logic [H_WIDTH:0] H_ONE_X = (H_WIDTH + 1)'(1);
    localparam logic [V_WIDTH:0] V_ONE_X = (V_WIDTH + 1)'(1);

    logic cfg_bad;
    logic pos_sat;

    // One extra bit so a back porch of all-ones does not wrap back+1 to 0.
    assign cfg_bad = ({1'b0, h_front} <= ({1'b0, h_back} + H_ONE_X)) ||
                     ({1'b0, v_front} <= ({1'b0, v_back} + V_ONE_X));
    assign pos_sat = (hsync && (h_pos == H_MAX)) || (vsync && (v_pos == V_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else if (shadow_load) begin
            cfg_err <= cfg_bad;
        end else if (pos_sat) begin
            cfg_err <= 1'b1;
        end
    end
`else
    assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_cm_window_counter.sv
module tb_cm_window_counter;

`ifdef CM_WINDOW_COUNTER_CFG_ERR_EN
    localparam bit CFG_EN = 1'b1;
`else
    localparam bit CFG_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [10:0] h_back, h_front;
    logic [9:0]  v_back, v_front;
    logic        hsync, vsync;
    logic        pix_valid, line_end, frame_end, cfg_err;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;

    logic [3:0]  h_back4, h_front4;
    logic        pix_valid4, line_end4, frame_end4, cfg_err4;
    logic [3:0]  pix_x4;
    logic [9:0]  pix_y4;

    int total = 0;
    int bad   = 0;
    int le_cnt, fe_cnt, both_cnt, v4_cnt;

    logic [20:0] sb[$];
    logic [13:0] sb4[$];

    cm_window_counter dut (
        .clk(clk), .rst(rst),
        .h_back(h_back), .h_front(h_front), .v_back(v_back), .v_front(v_front),
        .hsync(hsync), .vsync(vsync),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .line_end(line_end), .frame_end(frame_end), .cfg_err(cfg_err)
    );

    cm_window_counter #(.H_WIDTH(4), .V_WIDTH(10)) dut4 (
        .clk(clk), .rst(rst),
        .h_back(h_back4), .h_front(h_front4), .v_back(v_back), .v_front(v_front),
        .hsync(hsync), .vsync(vsync),
        .pix_valid(pix_valid4), .pix_x(pix_x4), .pix_y(pix_y4),
        .line_end(line_end4), .frame_end(frame_end4), .cfg_err(cfg_err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock; observes both DUTs at the falling edge and checks every
    // valid pixel against the expected-pixel queues.
    task automatic cycle();
        logic [20:0] e;
        logic [13:0] e4;
        @(posedge clk);
        @(negedge clk);
        if (pix_valid) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pixel: got x=%0d y=%0d, required no pixel", pix_x, pix_y);
            end else begin
                e = sb.pop_front();
                if ({pix_x, pix_y} !== e) begin
                    bad++;
                    $display("FAIL pixel: got x=%0d y=%0d, required x=%0d y=%0d",
                             pix_x, pix_y, e[20:10], e[9:0]);
                end
            end
        end
        if (pix_valid4) begin
            v4_cnt++;
            total++;
            if (sb4.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pixel4: got x=%0d y=%0d, required no pixel", pix_x4, pix_y4);
            end else begin
                e4 = sb4.pop_front();
                if ({pix_x4, pix_y4} !== e4) begin
                    bad++;
                    $display("FAIL pixel4: got x=%0d y=%0d, required x=%0d y=%0d",
                             pix_x4, pix_y4, e4[13:10], e4[9:0]);
                end
            end
        end
        if (line_end) le_cnt++;
        if (frame_end) fe_cnt++;
        if (line_end && frame_end) both_cnt++;
    endtask

    // Drives one vsync frame of nlines lines and predicts its pixels from
    // the porch values present at the vsync rising edge.
    task automatic run_frame(input string name, input int nlines, input int hi, input int lo,
                             input int chg_line, input int chg_front);
        int m_hb, m_hf, m_vb, m_vf, cnt, y, exp_le;
        m_hb = int'(h_back); m_hf = int'(h_front);
        m_vb = int'(v_back); m_vf = int'(v_front);
        le_cnt = 0; fe_cnt = 0; y = 0; exp_le = 0;
        vsync = 1'b1;
        cycle(); cycle();
        for (int k = 0; k < nlines; k++) begin
            if (k == chg_line) h_front = 11'(chg_front);
            cnt = 0;
            if (k > m_vb && k < m_vf)
                for (int h = 0; h < hi; h++)
                    if (h > m_hb && h < m_hf) cnt++;
            for (int p = 0; p < cnt; p++) sb.push_back({11'(p), 10'(y)});
            if (cnt > 0) begin
                exp_le++;
                y++;
            end
            hsync = 1'b1;
            repeat (hi) cycle();
            hsync = 1'b0;
            repeat (lo) cycle();
        end
        vsync = 1'b0;
        repeat (3) cycle();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s missing_pixels: got %0d left over, required 0", name, sb.size());
            sb.delete();
        end
        total++;
        if (le_cnt != exp_le) begin
            bad++;
            $display("FAIL %s line_end_count: got %0d, required %0d", name, le_cnt, exp_le);
        end
        total++;
        if (fe_cnt != 1) begin
            bad++;
            $display("FAIL %s frame_end_count: got %0d, required 1", name, fe_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({pix_valid, pix_x, pix_y, line_end, frame_end, cfg_err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b x=%0d y=%0d le=%b fe=%b err=%b, required all 0",
                     pix_valid, pix_x, pix_y, line_end, frame_end, cfg_err);
        end
        total++;
        if ({pix_valid4, pix_x4, pix_y4, line_end4, frame_end4, cfg_err4} !== '0) begin
            bad++;
            $display("FAIL reset_outputs4: got v=%b x=%0d y=%0d le=%b fe=%b err=%b, required all 0",
                     pix_valid4, pix_x4, pix_y4, line_end4, frame_end4, cfg_err4);
        end
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_basic_window();
        h_back = 11'd2; h_front = 11'd7; v_back = 10'd1; v_front = 10'd4;
        run_frame("basic", 6, 10, 3, -1, 0);
        total++;
        if (cfg_err !== 1'b0) begin
            bad++;
            $display("FAIL basic_cfg_err: got %b, required 0", cfg_err);
        end
    endtask

    task automatic test_shadowing();
        h_back = 11'd2; h_front = 11'd7; v_back = 10'd1; v_front = 10'd4;
        run_frame("shadow_cur", 6, 10, 3, 1, 9);
        run_frame("shadow_next", 6, 10, 3, -1, 0);
    endtask

    task automatic test_degenerate();
        h_back = 11'd5; h_front = 11'd6; v_back = 10'd1; v_front = 10'd4;
        run_frame("degen_h", 6, 10, 3, -1, 0);
        total++;
        if (cfg_err !== CFG_EN) begin
            bad++;
            $display("FAIL degen_h_cfg_err: got %b, required %b", cfg_err, CFG_EN);
        end
        h_back = 11'd2; h_front = 11'd7; v_back = 10'd3; v_front = 10'd4;
        run_frame("degen_v", 6, 10, 3, -1, 0);
        total++;
        if (cfg_err !== CFG_EN) begin
            bad++;
            $display("FAIL degen_v_cfg_err: got %b, required %b", cfg_err, CFG_EN);
        end
    endtask

    task automatic test_saturation();
        h_back = 11'd5; h_front = 11'd6; v_back = 10'd0; v_front = 10'd2;
        h_back4 = 4'd12; h_front4 = 4'd15;
        v4_cnt = 0;
        vsync = 1'b1;
        cycle(); cycle();
        total++;
        if (cfg_err4 !== 1'b0) begin
            bad++;
            $display("FAIL sat_cfg_err_load: got %b, required 0", cfg_err4);
        end
        hsync = 1'b1; repeat (2) cycle();
        hsync = 1'b0; repeat (3) cycle();
        sb4.push_back({4'd0, 10'd0});
        sb4.push_back({4'd1, 10'd0});
        hsync = 1'b1; repeat (40) cycle();
        hsync = 1'b0; repeat (3) cycle();
        total++;
        if (v4_cnt != 2) begin
            bad++;
            $display("FAIL sat_valid_count: got %0d, required 2", v4_cnt);
        end
        total++;
        if (sb4.size() != 0) begin
            bad++;
            $display("FAIL sat_missing_pixels: got %0d left over, required 0", sb4.size());
            sb4.delete();
        end
        total++;
        if (cfg_err4 !== CFG_EN) begin
            bad++;
            $display("FAIL sat_cfg_err: got %b, required %b", cfg_err4, CFG_EN);
        end
        vsync = 1'b0;
        repeat (3) cycle();
    endtask

    task automatic test_coincident_falls();
        h_back = 11'd0; h_front = 11'd20; v_back = 10'd0; v_front = 10'd5;
        le_cnt = 0; fe_cnt = 0; both_cnt = 0;
        vsync = 1'b1;
        cycle(); cycle();
        hsync = 1'b1; repeat (4) cycle();
        hsync = 1'b0; repeat (3) cycle();
        for (int p = 0; p < 4; p++) sb.push_back({11'(p), 10'd0});
        hsync = 1'b1; repeat (5) cycle();
        hsync = 1'b0; vsync = 1'b0;
        cycle();
        total++;
        if ({line_end, frame_end} !== 2'b11) begin
            bad++;
            $display("FAIL coincident_pulses: got le=%b fe=%b, required le=1 fe=1", line_end, frame_end);
        end
        repeat (3) cycle();
        total++;
        if (pix_y !== 10'd0) begin
            bad++;
            $display("FAIL coincident_pix_y: got %0d, required 0", pix_y);
        end
        total++;
        if (both_cnt != 1 || le_cnt != 1 || fe_cnt != 1) begin
            bad++;
            $display("FAIL coincident_counts: got both=%0d le=%0d fe=%0d, required 1 1 1",
                     both_cnt, le_cnt, fe_cnt);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL coincident_missing_pixels: got %0d left over, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_mid_line();
        bit found;
        h_back = 11'd2; h_front = 11'd7; v_back = 10'd0; v_front = 10'd5;
        vsync = 1'b1;
        cycle(); cycle();
        hsync = 1'b1; repeat (3) cycle();
        hsync = 1'b0; repeat (3) cycle();
        for (int p = 0; p < 4; p++) sb.push_back({11'(p), 10'd0});
        hsync = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (pix_valid && pix_x == 11'd2) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL rst_reach_x2: got no pixel x=2 within 20 cycles, required one");
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({pix_valid, pix_x, pix_y, line_end, frame_end, cfg_err} !== '0) begin
            bad++;
            $display("FAIL rst_async: got v=%b x=%0d y=%0d le=%b fe=%b err=%b, required all 0",
                     pix_valid, pix_x, pix_y, line_end, frame_end, cfg_err);
        end
        sb.delete();
        cycle();
        total++;
        if (pix_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_held: got pix_valid=%b, required 0", pix_valid);
        end
        rst = 1'b0;
        hsync = 1'b0; vsync = 1'b0;
        cycle();
        for (int k = 0; k < 3; k++) begin
            hsync = 1'b1; repeat (8) cycle();
            hsync = 1'b0; repeat (3) cycle();
        end
        h_back = 11'd2; h_front = 11'd7; v_back = 10'd1; v_front = 10'd4;
        run_frame("after_rst", 6, 10, 3, -1, 0);
    endtask

    initial begin
        rst = 1'b1;
        h_back = '0; h_front = '0; v_back = '0; v_front = '0;
        h_back4 = 4'd12; h_front4 = 4'd15;
        hsync = 1'b0; vsync = 1'b0;
        le_cnt = 0; fe_cnt = 0; both_cnt = 0; v4_cnt = 0;
        test_reset();
        test_basic_window();
        test_shadowing();
        test_degenerate();
        test_saturation();
        test_coincident_falls();
        test_reset_mid_line();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
